// File: rtl/mips_pkg.sv
// Shared types for the MIPS register writeback slice.
// WB_PARTIAL_LOAD_EN enables LWL/LWR handling.
package mips_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } load_type_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } wb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic misaligned(
    input load_type_t t,
    input logic [1:0] off
  );
    logic r;
    case (t)
      LB, LBU:  r = 1'b0;
      LH, LHU:  r = off[0];
      LW:       r = (off != 2'd0);
`ifdef WB_PARTIAL_LOAD_EN
      LWL, LWR: r = 1'b0;
`endif
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_load_align.sv
// Load lane extraction and LWL/LWR merge (combinational).
// Merge paths exist only with WB_PARTIAL_LOAD_EN defined.
module mips_load_align
  import mips_pkg::*;
(
  input  load_type_t  ltype,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] oldval,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];

`ifdef WB_PARTIAL_LOAD_EN
  logic [4:0]  sh_l;
  logic [4:0]  sh_r;
  logic [31:0] lwl;
  logic [31:0] lwr;

  // ~off == 3-off: LWL shifts memory up, LWR shifts it down
  assign sh_l = {~off, 3'b000};
  assign sh_r = {off, 3'b000};
  assign lwl  = (rdata << sh_l)
              | (oldval & ~(32'hFFFF_FFFF << sh_l));
  assign lwr  = (rdata >> sh_r)
              | (oldval & ~(32'hFFFF_FFFF >> sh_r));
`else
  logic unused_old;
  assign unused_old = ^oldval;
`endif

  always_comb begin
    data = '0;
    unique case (1'b1)
      (ltype == LB):  data = {{24{b[7]}}, b};
      (ltype == LBU): data = {24'd0, b};
      (ltype == LH):  data = {{16{h[15]}}, h};
      (ltype == LHU): data = {16'd0, h};
      (ltype == LW):  data = rdata;
`ifdef WB_PARTIAL_LOAD_EN
      (ltype == LWL): data = lwl;
      (ltype == LWR): data = lwr;
`endif
      default:        data = '0;
    endcase
  end

endmodule

// File: rtl/mips_reg_writeback.sv
// Register-file writeback: load FSM, ALU path, collision skid.
// WB_PARTIAL_LOAD_EN enables LWL/LWR merge loads.
module mips_reg_writeback
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_result,
  input  logic        load_start,
  input  logic [4:0]  load_dest,
  input  logic [2:0]  load_type,
  input  logic [1:0]  load_offset,
  input  logic [31:0] load_oldval,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        RegWrite,
  output logic [4:0]  WriteAddress,
  output logic [31:0] DataIn,
  output logic        busy,
  output logic        stall,
  output logic        addr_error,
  output logic        timeout_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  wb_state_t   state;
  wb_state_t   state_nx;
  logic [CW-1:0] cnt;
  logic [4:0]  dest_q;
  load_type_t  type_q;
  logic [1:0]  off_q;
  logic [31:0] old_q;
  logic [31:0] ld_data;
  logic        skid_v;
  logic [4:0]  skid_dest;
  logic [31:0] skid_data;
  load_type_t  ltype_in;
  logic        accept;
  logic        bad;
  logic        go;
  logic        mem_done;
  logic        tmo;
  logic        ld_wr;
  logic        alu_wr;

  assign ltype_in = load_type_t'(load_type);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (go) state_nx = WAIT_MEM;
      WAIT_MEM: begin
        if (mem_done) state_nx = WRITE;
        else if (tmo) state_nx = IDLE;
      end
      WRITE:    state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept   = load_start && (state == IDLE);
    bad      = accept && misaligned(ltype_in, load_offset);
    go       = accept && !bad;
    mem_done = (state == WAIT_MEM) && !mem_waitrequest;
    tmo      = (state == WAIT_MEM) && mem_waitrequest
             && (cnt == CNT_LAST);
    ld_wr    = mem_done && (dest_q != REG_ZERO);
    alu_wr   = alu_valid && (alu_dest != REG_ZERO);
    busy     = (state != IDLE);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      dest_q        <= '0;
      type_q        <= LB;
      off_q         <= '0;
      addr_error    <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      addr_error <= bad;
      if (tmo) timeout_error <= 1'b1;
      if (go) begin
        cnt    <= '0;
        dest_q <= load_dest;
        type_q <= ltype_in;
        off_q  <= load_offset;
      end else if ((state == WAIT_MEM) && mem_waitrequest) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef WB_PARTIAL_LOAD_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)  old_q <= '0;
    else if (go) old_q <= load_oldval;
  end
`else
  logic unused_oldval;
  assign unused_oldval = ^load_oldval;
  assign old_q = '0;
`endif

  mips_load_align u_align (
    .ltype  (type_q),
    .off    (off_q),
    .rdata  (mem_readdata),
    .oldval (old_q),
    .data   (ld_data)
  );

  // Load wins a collision; the ALU entry waits one cycle in the skid
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite     <= 1'b0;
      WriteAddress <= '0;
      DataIn       <= '0;
      stall        <= 1'b0;
      skid_v       <= 1'b0;
      skid_dest    <= '0;
      skid_data    <= '0;
    end else begin
      stall <= ld_wr && alu_wr;
      if (ld_wr) begin
        RegWrite     <= 1'b1;
        WriteAddress <= dest_q;
        DataIn       <= ld_data;
        if (alu_wr) begin
          skid_v    <= 1'b1;
          skid_dest <= alu_dest;
          skid_data <= alu_result;
        end
      end else if (skid_v) begin
        RegWrite     <= 1'b1;
        WriteAddress <= skid_dest;
        DataIn       <= skid_data;
        skid_v       <= 1'b0;
      end else if (alu_wr) begin
        RegWrite     <= 1'b1;
        WriteAddress <= alu_dest;
        DataIn       <= alu_result;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_reg_writeback.sv
// Randomized bench for mips_reg_writeback with a byte-level model.
// Honours WB_PARTIAL_LOAD_EN the same way as the design.
module tb_mips_reg_writeback;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_result;
  logic        load_start;
  logic [4:0]  load_dest;
  logic [2:0]  load_type;
  logic [1:0]  load_offset;
  logic [31:0] load_oldval;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        RegWrite;
  logic [4:0]  WriteAddress;
  logic [31:0] DataIn;
  logic        busy;
  logic        stall;
  logic        addr_error;
  logic        timeout_error;

  always #5 CLK = ~CLK;

  mips_reg_writeback dut (
    .CLK             (CLK),
    .rst_n           (rst_n),
    .alu_valid       (alu_valid),
    .alu_dest        (alu_dest),
    .alu_result      (alu_result),
    .load_start      (load_start),
    .load_dest       (load_dest),
    .load_type       (load_type),
    .load_offset     (load_offset),
    .load_oldval     (load_oldval),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest),
    .RegWrite        (RegWrite),
    .WriteAddress    (WriteAddress),
    .DataIn          (DataIn),
    .busy            (busy),
    .stall           (stall),
    .addr_error      (addr_error),
    .timeout_error   (timeout_error)
  );

  int n_chk = 0;
  int n_pass = 0;
  int ae_cnt = 0;
  logic [36:0] wq[$];
  logic [4:0]  lw_addr = '0;
  logic [31:0] lw_data = '0;

  always @(negedge CLK) begin
    if (RegWrite) begin
      wq.push_back({WriteAddress, DataIn});
      lw_addr = WriteAddress;
      lw_data = DataIn;
    end
    if (addr_error) ae_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic bit ref_ok(input int t, input int off);
    case (t)
      0, 1:    return 1'b1;
      2, 3:    return (off % 2) == 0;
      4:       return off == 0;
`ifdef WB_PARTIAL_LOAD_EN
      5, 6:    return 1'b1;
`else
      5, 6:    return 1'b0;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int t, input int off,
                                           input logic [31:0] m,
                                           input logic [31:0] o);
    int mb[4];
    int ob[4];
    int rb[4];
    int v;
    for (int i = 0; i < 4; i++) begin
      mb[i] = (m >> (8 * i)) & 255;
      ob[i] = (o >> (8 * i)) & 255;
    end
    case (t)
      0: begin
        v = mb[off];
        if (v >= 128) v = v - 256;
        return 32'(v);
      end
      1: return 32'(mb[off]);
      2: begin
        v = mb[off + 1] * 256 + mb[off];
        if (v >= 32768) v = v - 65536;
        return 32'(v);
      end
      3: return 32'(mb[off + 1] * 256 + mb[off]);
      4: return m;
      5: for (int i = 0; i < 4; i++)
           rb[i] = (i >= 3 - off) ? mb[i - (3 - off)] : ob[i];
      6: for (int i = 0; i < 4; i++)
           rb[i] = (i < 4 - off) ? mb[i + off] : ob[i];
      default: return 32'd0;
    endcase
    return {8'(rb[3]), 8'(rb[2]), 8'(rb[1]), 8'(rb[0])};
  endfunction

  task automatic do_load(input int t, input int off, input int dest,
                         input logic [31:0] old, input logic [31:0] rd,
                         input int waits);
    bit bsy;
    bit we;
    wq.delete();
    ae_cnt = 0;
    load_start      = 1'b1;
    load_type       = 3'(t);
    load_offset     = 2'(off);
    load_dest       = 5'(dest);
    load_oldval     = old;
    mem_readdata    = rd;
    mem_waitrequest = (waits > 0);
    tick;
    load_start = 1'b0;
    if (!ref_ok(t, off)) begin
      chk("ae_pulse", addr_error, 1);
      chk("ae_busy", busy, 0);
      tick;
      chk("ae_clear", addr_error, 0);
      chk("ae_nowr", wq.size(), 0);
    end else begin
      chk("ld_busy", busy, 1);
      chk("ld_ae", addr_error, 0);
      bsy = 1'b1;
      for (int i = 0; i < waits; i++) begin
        load_start  = 1'b1;
        load_type   = 3'd2;
        load_offset = 2'd1;
        tick;
        bsy = bsy & busy;
      end
      load_start      = 1'b0;
      mem_waitrequest = 1'b0;
      tick;
      we  = (dest != 0);
      bsy = bsy & busy;
      chk("ld_latency", RegWrite, we);
      tick;
      chk("ld_idle", busy, 0);
      chk("ld_nwrites", wq.size(), we);
      chk("ld_ignored", ae_cnt, 0);
      chk("ld_busyall", bsy, 1);
      if (we && wq.size() > 0) begin
        chk("ld_addr", wq[0][36:32], dest);
        chk("ld_data", wq[0][31:0], ref_load(t, off, rd, old));
      end
    end
  endtask

  task automatic do_alu(input int dest, input logic [31:0] d);
    bit we;
    alu_valid  = 1'b1;
    alu_dest   = 5'(dest);
    alu_result = d;
    tick;
    alu_valid = 1'b0;
    we = (dest != 0);
    chk("alu_we", RegWrite, we);
    if (we) begin
      chk("alu_addr", WriteAddress, dest);
      chk("alu_data", DataIn, d);
    end
    tick;
    chk("alu_off", RegWrite, 0);
    if (we) chk("alu_hold", DataIn, d);
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_dest = '0; alu_result = '0;
    load_start = 1'b0; load_dest = '0; load_type = '0;
    load_offset = '0; load_oldval = '0;
    mem_readdata = '0; mem_waitrequest = 1'b0;
    repeat (3) tick;
    chk("rst_we", RegWrite, 0);
    chk("rst_wa", WriteAddress, 0);
    chk("rst_di", DataIn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ae", addr_error, 0);
    chk("rst_to", timeout_error, 0);
    rst_n = 1'b1;

    do_load(0, 2, 5, 32'h0, 32'h12F45678, 0);
    chk("lb_addr", lw_addr, 5);
    chk("lb_data", lw_data, 32'hFFFFFFF4);

    do_load(3, 2, 12, 32'h0, 32'h8001ABCD, 3);
    chk("lhu_data", lw_data, 32'h00008001);

    do_load(5, 1, 4, 32'hAABBCCDD, 32'h11223344, 1);
`ifdef WB_PARTIAL_LOAD_EN
    chk("lwl_data", lw_data, 32'h3344CCDD);
`endif

    wq.delete();
    r = $urandom;
    load_start = 1'b1; load_type = 3'd4; load_offset = 2'd0;
    load_dest = 5'd9; mem_readdata = r; mem_waitrequest = 1'b0;
    tick;
    load_start = 1'b0;
    alu_valid = 1'b1; alu_dest = 5'd7; alu_result = 32'hDEADBEEF;
    tick;
    alu_valid = 1'b0;
    chk("col_stall", stall, 1);
    chk("col_we1", RegWrite, 1);
    chk("col_wa1", WriteAddress, 9);
    chk("col_di1", DataIn, r);
    tick;
    chk("col_unstall", stall, 0);
    chk("col_we2", RegWrite, 1);
    chk("col_wa2", WriteAddress, 7);
    chk("col_di2", DataIn, 32'hDEADBEEF);
    tick;
    chk("col_off", RegWrite, 0);
    chk("col_n", wq.size(), 2);

    do_alu(0, $urandom);
    do_load(2, 1, 6, 32'h0, $urandom, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0)
        do_alu($urandom_range(0, 31), $urandom);
      do_load($urandom_range(0, 6), $urandom_range(0, 3),
              $urandom_range(0, 31), $urandom, $urandom,
              $urandom_range(0, 4));
    end

    wq.delete();
    load_start = 1'b1; load_type = 3'd4; load_offset = 2'd0;
    load_dest = 5'd8; mem_waitrequest = 1'b1;
    tick;
    load_start = 1'b0;
    repeat (2) tick;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", RegWrite, 0);
    tick;
    rst_n = 1'b1;
    mem_waitrequest = 1'b0;
    repeat (3) tick;
    chk("mid_rst_nowr", wq.size(), 0);

    wq.delete();
    load_start = 1'b1; load_type = 3'd4; load_offset = 2'd0;
    load_dest = 5'd3; mem_waitrequest = 1'b1;
    tick;
    load_start = 1'b0;
    repeat (254) tick;
    chk("to_pre", timeout_error, 0);
    chk("to_pre_busy", busy, 1);
    tick;
    chk("to_set", timeout_error, 1);
    chk("to_idle", busy, 0);
    mem_waitrequest = 1'b0;
    repeat (2) tick;
    chk("to_nowr", wq.size(), 0);
    do_load(1, 3, 11, 32'h0, $urandom, 0);
    chk("to_sticky", timeout_error, 1);
    rst_n = 1'b0;
    #1;
    chk("to_clear", timeout_error, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("to_after", timeout_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
